// File: rtl/fib_pkg.sv
// Shared types and constants for the fibonacci scheduler.
package fib_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_GUARD,
    S_WAIT,
    S_RESP
  } state_t;

  typedef logic [15:0] u16_t;

  // fib(24) = 46368 is the largest value that fits in 16 bits.
  localparam int unsigned FIB_MAX_N = 24;
  localparam u16_t        FIB0      = 16'd0;
  localparam u16_t        FIB1      = 16'd1;

  // True when fib(n) fits the 16-bit result path.
  function automatic logic fib_legal(input u16_t n, input int unsigned max_n);
    return 32'(n) <= max_n;
  endfunction

endpackage

// File: rtl/fib_sched_if.sv
// Requester and engine signal bundle for fib_sched.
interface fib_sched_if #(
  parameter int unsigned NREQ = 4
);
  import fib_pkg::*;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*16-1:0] req_n;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    resp_valid;
  u16_t               resp_data;
  logic               resp_err;
  logic               busy;
  logic               fib_start;
  u16_t               fib_din;
  u16_t               fib_dout;
  logic               fib_done;

  // Scheduler side.
  modport slave (
    input  req_valid, req_n, fib_dout, fib_done,
    output req_ready, resp_valid, resp_data, resp_err, busy, fib_start, fib_din
  );

  // Requesters plus engine side.
  modport master (
    output req_valid, req_n, fib_dout, fib_done,
    input  req_ready, resp_valid, resp_data, resp_err, busy, fib_start, fib_din
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above
// ptr, wrapping around. Output is one-hot, or zero when nothing is requested.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [NREQ-1:0]   low_rot;
  logic [2*NREQ-1:0] grant_dbl;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req_dbl   = {req, req} >> ptr;
    req_rot   = req_dbl[NREQ-1:0];
    low_rot   = req_rot & (~req_rot + NREQ'(1));
    grant_dbl = {low_rot, low_rot} << ptr;
    grant     = grant_dbl[2*NREQ-1:NREQ];
  end

endmodule

// File: rtl/fib_sched.sv
// Round-robin scheduler sharing one fibonacci engine among NREQ requesters.
// Out-of-range indices are rejected without touching the engine; a stuck
// engine is abandoned after TIMEOUT wait cycles.
module fib_sched
  import fib_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MAX_N   = FIB_MAX_N,
  parameter int unsigned GUARD   = 2,
  parameter int unsigned TIMEOUT = 1023
) (
  input logic        clk,
  input logic        reset,
  fib_sched_if.slave bus
);

  localparam int unsigned PtrW = $clog2(NREQ);
  localparam int unsigned CntW = 10;
  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t GuardLast   = cnt_t'(GUARD - 1);
  localparam cnt_t TimeoutLast = cnt_t'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] winner_q, winner_d;
  u16_t            n_q, n_d;
  cnt_t            cnt_q, cnt_d;
  logic [NREQ-1:0] req_ready_q, req_ready_d;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  u16_t            resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;
  logic            busy_q, busy_d;
  logic            fib_start_q, fib_start_d;
  u16_t            fib_din_q, fib_din_d;

  logic [NREQ-1:0]            grant;
  logic [PtrW-1:0]            grant_idx;
  u16_t                       grant_n;
  logic [PtrW-1:0]            ptr_next;
  logic [NREQ-1:0][15:0]      req_n_arr;

  assign req_n_arr = bus.req_n;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req  (bus.req_valid),
    .ptr  (rr_ptr_q),
    .grant(grant)
  );

  // Convert the one-hot grant into an index and pick out that slot's n.
  always_comb begin
    grant_idx = '0;
    grant_n   = FIB0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[PtrW'(k)]) begin
        grant_idx = PtrW'(k);
        grant_n   = req_n_arr[PtrW'(k)];
      end
    end
    ptr_next = (grant_idx == PtrW'(NREQ - 1)) ? '0 : grant_idx + PtrW'(1);
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    winner_d     = winner_q;
    n_d          = n_q;
    cnt_d        = cnt_q;
    req_ready_d  = '0;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    fib_start_d  = 1'b0;
    fib_din_d    = fib_din_q;

    unique case (state_q)
      S_IDLE: begin
        if (|bus.req_valid) begin
          winner_d    = grant;
          n_d         = grant_n;
          req_ready_d = grant;
          rr_ptr_d    = ptr_next;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!fib_legal(n_q, MAX_N)) begin
          resp_err_d  = 1'b1;
          resp_data_d = FIB0;
          state_d     = S_RESP;
        end else begin
          fib_din_d   = n_q;
          fib_start_d = 1'b1;
          cnt_d       = '0;
          state_d     = (GUARD == 0) ? S_WAIT : S_GUARD;
        end
      end
      S_GUARD: begin
        // fib_done may still reflect the previous job here.
        if (cnt_q >= GuardLast) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      S_WAIT: begin
        // done takes priority over a coincident timeout.
        if (bus.fib_done) begin
          resp_data_d = bus.fib_dout;
          resp_err_d  = 1'b0;
          state_d     = S_RESP;
        end else if (cnt_q >= TimeoutLast) begin
          resp_data_d = FIB0;
          resp_err_d  = 1'b1;
          state_d     = S_RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      S_RESP: begin
        resp_valid_d = winner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      winner_q     <= '0;
      n_q          <= FIB0;
      cnt_q        <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= FIB0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      fib_start_q  <= 1'b0;
      fib_din_q    <= FIB0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      winner_q     <= winner_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
      fib_start_q  <= fib_start_d;
      fib_din_q    <= fib_din_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.busy       = busy_q;
  assign bus.fib_start  = fib_start_q;
  assign bus.fib_din    = fib_din_q;

endmodule

// File: tb/tb_fib_sched.sv
// Scoreboard bench for fib_sched: accepted requests push the expected
// response; a negedge monitor pops and compares each response pulse.
module tb_fib_sched;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned PW      = $clog2(NREQ);
  localparam int unsigned MAX_N   = 24;
  localparam int unsigned GUARD   = 2;
  localparam int unsigned TIMEOUT = 1023;

  localparam int ENG_NORMAL = 0;
  localparam int ENG_STALE  = 1;
  localparam int ENG_NEVER  = 2;

  typedef struct {
    int idx;
    int n;
    int data;
    int err;
    int legal;
    int lat;
    int t;
    int starts;
  } job_t;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0][15:0] req_n;
  logic [15:0]           eng_dout;
  logic                  eng_done;
  int                    eng_mode;
  int                    eng_lat;
  int                    cyc;
  int                    n_checks;
  int                    n_err;
  job_t                  sb[$];

  fib_sched_if #(.NREQ(NREQ)) bus ();

  assign bus.req_valid = req_valid;
  assign bus.req_n     = req_n;
  assign bus.fib_dout  = eng_dout;
  assign bus.fib_done  = eng_done;

  fib_sched #(
    .NREQ   (NREQ),
    .MAX_N  (MAX_N),
    .GUARD  (GUARD),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: run still active, required to finish");
    $fatal(1, "watchdog");
  end

  function automatic int fib_ref(input int n);
    int a = 0;
    int b = 1;
    int t;
    for (int k = 0; k < n; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      int j = (ptr + k) % NREQ;
      if (((v >> j) & 1) != 0) return j;
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engine model: NORMAL answers after eng_lat cycles, STALE keeps the old
  // done level through the guard window, NEVER stays silent.
  initial begin
    int nn;
    eng_done = 1'b0;
    eng_dout = 16'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && bus.fib_start) begin
        nn = int'(bus.fib_din);
        if (eng_mode == ENG_NEVER) begin
          eng_done = 1'b0;
        end else if (eng_mode == ENG_STALE) begin
          eng_done = 1'b1;
          repeat (GUARD) @(posedge clk);
          #1 eng_done = 1'b0;
          repeat (5 - GUARD) @(posedge clk);
          #1;
          eng_dout = 16'(fib_ref(nn));
          eng_done = 1'b1;
        end else begin
          eng_done = 1'b0;
          if (eng_lat > 0) begin
            repeat (eng_lat) @(posedge clk);
            #1;
          end
          eng_dout = 16'(fib_ref(nn));
          eng_done = 1'b1;
        end
      end
    end
  end

  // Requesters drop valid right after the cycle they were accepted in.
  initial begin
    logic [NREQ-1:0] rdy;
    forever begin
      @(negedge clk);
      if (!reset && bus.req_ready != '0) begin
        rdy = bus.req_ready;
        @(posedge clk);
        #1 req_valid = req_valid & ~rdy;
      end
    end
  end

  // Monitor: model arbitration at accept time, check engine launch and responses.
  initial begin
    logic [NREQ-1:0]       prev_valid;
    logic [NREQ-1:0][15:0] prev_n;
    int                    mptr;
    int                    w;
    logic                  start_prev;
    job_t                  e;
    prev_valid = '0;
    prev_n     = '0;
    mptr       = 0;
    start_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
        mptr       = 0;
        prev_valid = '0;
        start_prev = 1'b0;
      end else begin
        if (bus.req_ready != '0) begin
          w = rr_pick(prev_valid, mptr);
          check("accept_while_pending", sb.size(), 0);
          check("busy_at_accept", int'(bus.busy), 1);
          check("grant_onehot", int'(bus.req_ready), (w < 0) ? 0 : (1 << w));
          if (w >= 0) begin
            e.idx    = w;
            e.n      = int'(prev_n[PW'(w)]);
            e.legal  = (e.n <= int'(MAX_N)) ? 1 : 0;
            e.t      = cyc;
            e.starts = 0;
            if (e.legal == 0) begin
              e.data = 0;
              e.err  = 1;
              e.lat  = 2;
            end else if (eng_mode == ENG_NEVER) begin
              e.data = 0;
              e.err  = 1;
              e.lat  = int'(TIMEOUT) + 4;
            end else begin
              e.data = fib_ref(e.n);
              e.err  = 0;
              e.lat  = (eng_mode == ENG_STALE) ? 8 : eng_lat + 3;
              if (e.lat < int'(GUARD) + 3) e.lat = int'(GUARD) + 3;
            end
            sb.push_back(e);
            mptr = (w + 1) % NREQ;
          end
        end
        if (bus.fib_start) begin
          check("start_single_cycle", int'(start_prev), 0);
          if (sb.size() == 0) begin
            check("start_without_job", int'(bus.fib_start), 0);
          end else begin
            check("fib_din", int'(bus.fib_din), sb[0].n);
            check("start_latency", cyc - sb[0].t, 1);
            sb[0].starts = sb[0].starts + 1;
          end
        end
        start_prev = bus.fib_start;
        if (bus.resp_valid != '0) begin
          if (sb.size() == 0) begin
            check("resp_without_job", int'(bus.resp_valid), 0);
          end else begin
            e = sb.pop_front();
            check("resp_target", int'(bus.resp_valid), 1 << e.idx);
            check("resp_data", int'(bus.resp_data), e.data);
            check("resp_err", int'(bus.resp_err), e.err);
            check("resp_latency", cyc - e.t, e.lat);
            check("engine_launches", e.starts, e.legal);
            check("busy_at_resp", int'(bus.busy), 0);
          end
        end
        prev_valid = req_valid;
        prev_n     = req_n;
      end
    end
  end

  task automatic issue(input int i, input int n);
    while (req_valid[PW'(i)]) begin
      @(posedge clk);
      #2;
    end
    req_n[PW'(i)]     = 16'(n);
    req_valid[PW'(i)] = 1'b1;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((req_valid != '0 || sb.size() != 0) && k < budget) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (k >= budget) check("drain_timeout", sb.size() + int'(req_valid != '0), 0);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, int'(bus.req_ready), 0);
    check({tag, "_resp_valid"}, int'(bus.resp_valid), 0);
    check({tag, "_resp_data"}, int'(bus.resp_data), 0);
    check({tag, "_resp_err"}, int'(bus.resp_err), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_fib_start"}, int'(bus.fib_start), 0);
    check({tag, "_fib_din"}, int'(bus.fib_din), 0);
  endtask

  task automatic wait_start(input int budget);
    int k = 0;
    while (!bus.fib_start && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) check("start_seen", int'(bus.fib_start), 1);
  endtask

  initial begin
    n_checks  = 0;
    n_err     = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_n     = '0;
    eng_mode  = ENG_NORMAL;
    eng_lat   = 0;

    repeat (2) @(posedge clk);
    #1 check_outputs_zero("reset");
    @(posedge clk);
    #3 reset = 1'b0;

    // Single request, then the index boundaries (last one realigns ptr to 0).
    issue(0, 10);
    drain(100);
    eng_lat = int'($urandom_range(0, 6));
    issue(0, 0);
    drain(100);
    issue(1, 1);
    drain(100);
    issue(2, 24);
    drain(100);
    issue(3, 25);
    drain(100);

    // All requesters valid at once, requester 0 comes back for a second turn.
    eng_lat = int'($urandom_range(0, 6));
    issue(0, 3);
    issue(1, 4);
    issue(2, 5);
    issue(3, 6);
    issue(0, 8);
    drain(400);

    // Stale done level from the previous job must not be captured.
    eng_lat = 0;
    issue(0, 9);
    drain(100);
    eng_mode = ENG_STALE;
    issue(1, 15);
    drain(100);
    eng_mode = ENG_NORMAL;

    // Timeout on the first job, then the queued request is served normally.
    eng_mode = ENG_NEVER;
    issue(2, 12);
    issue(3, 11);
    wait_start(20);
    @(posedge clk);
    #2;
    eng_mode = ENG_NORMAL;
    eng_lat  = 2;
    drain(3000);

    // A request withdrawn while the engine is busy is never accepted.
    eng_lat = 6;
    issue(0, 20);
    wait_start(20);
    @(posedge clk);
    #2;
    req_n[3]     = 16'd5;
    req_valid[3] = 1'b1;
    repeat (3) @(posedge clk);
    #2 req_valid[3] = 1'b0;
    issue(1, 3);
    drain(200);

    // Randomized traffic.
    for (int r = 0; r < 2; r++) begin
      eng_lat = int'($urandom_range(0, 6));
      for (int j = 0; j < 16; j++) begin
        issue(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, 30)));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #2;
        end
      end
      drain(2000);
    end

    // Reset in the middle of a wait: outputs clear at once, no stale response.
    eng_mode = ENG_NEVER;
    issue(2, 9);
    wait_start(20);
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    #1 check_outputs_zero("midreset");
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    eng_mode = ENG_NORMAL;
    eng_lat  = 1;
    issue(0, 7);
    drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
